// File: rtl/video_int_ctrl_pkg.sv
// Shared video interrupt definitions: FSM state encoding, source indices,
// default IM2 vectors and the line-number width used by the sync generators.
package video_int_ctrl_pkg;

  localparam int unsigned LINE_W = 9;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } int_state_e;

  localparam int SRC_FRAME = 0;
  localparam int SRC_LINE  = 1;

  localparam logic [7:0] VEC_FRAME_DEF = 8'hFF;
  localparam logic [7:0] VEC_LINE_DEF  = 8'hFD;

  // Next line number, wrapping 511 -> 0.
  function automatic line_t line_next(input line_t l);
    return l + LINE_W'(1);
  endfunction

endpackage

// File: rtl/video_int_linecnt.sv
// Line counter and compare for the line interrupt source.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   int_start    : frame pulse, reloads the counter to line 0 (wins over tick)
//   line_tick    : one pulse per line, advances the counter
//   line_cmp     : target line; 0 never fires (line 0 is the frame event)
//   line_int_en  : source enable
//   line_evt     : combinational line event (next line value == line_cmp)
module video_int_linecnt
  import video_int_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  int_start,
  input  logic  line_tick,
  input  line_t line_cmp,
  input  logic  line_int_en,
  output logic  line_evt
);

  line_t line_q, line_d, line_nxt;

  always_comb begin
    line_nxt = line_next(line_q);
    line_d   = line_q;
    if (int_start) begin
      line_d = '0;
    end else if (line_tick) begin
      line_d = line_nxt;
    end
  end

  // Compare against the value the tick is about to produce.
  assign line_evt = line_tick & line_int_en & (line_cmp != '0) & (line_nxt == line_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/video_int_ctrl.sv
// Z80 /INT scheduler for the frame and line video interrupt sources.
// Fixed priority (frame over line), timed /INT width, minimum inactive gap,
// acknowledge handling and IM2 vector for the serviced source.
// Build option: VIDEO_INT_LINE_EN adds the line source; without it pend[1]
// stays 0, line inputs are ignored and the vector is always VEC_FRAME.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   int_start         : frame event pulse (line 0)
//   line_tick         : one pulse per line
//   line_cmp          : line number for the line interrupt
//   frame_int_en      : frame source enable
//   line_int_en       : line source enable
//   int_ack           : CPU acknowledge pulse, honoured only while asserting
//   stat_clr          : clears missed/overrun (a coincident set wins)
//   int_n             : Z80 /INT, active low
//   int_vector        : vector of the current/last serviced source
//   pend              : {line, frame} pending bits
//   missed, overrun   : sticky status flags
//
// state     | meaning
// ST_IDLE   | /INT high, waiting for a pending source
// ST_ASSERT | /INT low, width counter running, waiting for ack
// ST_GAP    | /INT high, enforcing the minimum inactive time
module video_int_ctrl
  import video_int_ctrl_pkg::*;
#(
  parameter int unsigned INT_WIDTH  = 256,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  VEC_FRAME  = VEC_FRAME_DEF,
  parameter logic [7:0]  VEC_LINE   = VEC_LINE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_start,
  input  logic              line_tick,
  input  logic [LINE_W-1:0] line_cmp,
  input  logic              frame_int_en,
  input  logic              line_int_en,
  input  logic              int_ack,
  input  logic              stat_clr,
  output logic              int_n,
  output logic [7:0]        int_vector,
  output logic [1:0]        pend,
  output logic              missed,
  output logic              overrun
);

  localparam logic [8:0] WIDTH_LOAD = 9'(INT_WIDTH - 1);
  localparam logic [8:0] GAP_LOAD   = 9'(GAP_CYCLES - 1);

  logic frame_evt, line_evt;

  assign frame_evt = int_start & frame_int_en;

`ifdef VIDEO_INT_LINE_EN
  video_int_linecnt u_linecnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_start   (int_start),
    .line_tick   (line_tick),
    .line_cmp    (line_cmp),
    .line_int_en (line_int_en),
    .line_evt    (line_evt)
  );
`else
  logic unused_line;
  assign unused_line = ^{line_tick, line_cmp, line_int_en};
  assign line_evt    = 1'b0;
`endif

  int_state_e state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;      // serviced source index: 0 frame, 1 line
  logic       int_n_q, int_n_d;
  logic [7:0] vec_q, vec_d;
  logic [1:0] pend_q, pend_d;
  logic       missed_q, missed_d;
  logic       overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    int_n_d   = int_n_q;
    vec_d     = vec_q;
    pend_d    = pend_q;
    missed_d  = missed_q;
    overrun_d = overrun_q;

    if (stat_clr) begin
      missed_d  = 1'b0;
      overrun_d = 1'b0;
    end

    // A source still pending is also the one in service, so one test covers both.
    if (frame_evt) begin
      if (pend_q[SRC_FRAME]) overrun_d = 1'b1;
      else                   pend_d[SRC_FRAME] = 1'b1;
    end
    if (line_evt) begin
      if (pend_q[SRC_LINE]) overrun_d = 1'b1;
      else                  pend_d[SRC_LINE] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_ASSERT;
          sel_d   = ~pend_q[SRC_FRAME];
          vec_d   = pend_q[SRC_FRAME] ? VEC_FRAME : VEC_LINE;
          int_n_d = 1'b0;
          cnt_d   = WIDTH_LOAD;
        end
      end
      ST_ASSERT: begin
        // Ack takes precedence over expiry in the same cycle.
        if (int_ack || cnt_q == '0) begin
          pend_d[sel_q] = 1'b0;
          int_n_d       = 1'b1;
          state_d       = ST_GAP;
          cnt_d         = GAP_LOAD;
          if (!int_ack) missed_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 9'd1;
      end
      default: begin
        state_d = ST_IDLE;
        int_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      int_n_q   <= 1'b1;
      vec_q     <= VEC_FRAME;
      pend_q    <= '0;
      missed_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      int_n_q   <= int_n_d;
      vec_q     <= vec_d;
      pend_q    <= pend_d;
      missed_q  <= missed_d;
      overrun_q <= overrun_d;
    end
  end

  assign int_n      = int_n_q;
  assign int_vector = vec_q;
  assign pend       = pend_q;
  assign missed     = missed_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_video_int_ctrl.sv
module tb_video_int_ctrl;

`ifdef VIDEO_INT_LINE_EN
  localparam bit LINE_BUILD = 1'b1;
`else
  localparam bit LINE_BUILD = 1'b0;
`endif
  localparam int INT_W = 256;
  localparam int GAP   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       int_start = 1'b0, line_tick = 1'b0, frame_int_en = 1'b0, line_int_en = 1'b0;
  logic       int_ack = 1'b0, stat_clr = 1'b0;
  logic [8:0] line_cmp = '0;
  logic       int_n, missed, overrun;
  logic [7:0] int_vector;
  logic [1:0] pend;

  int total = 0;
  int bad   = 0;

  video_int_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .int_start    (int_start),
    .line_tick    (line_tick),
    .line_cmp     (line_cmp),
    .frame_int_en (frame_int_en),
    .line_int_en  (line_int_en),
    .int_ack      (int_ack),
    .stat_clr     (stat_clr),
    .int_n        (int_n),
    .int_vector   (int_vector),
    .pend         (pend),
    .missed       (missed),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int_start = 0; line_tick = 0; int_ack = 0; stat_clr = 0;
    frame_int_en = 0; line_int_en = 0; line_cmp = '0;
    rst_n = 0;
    repeat (2) tick_clk();
    rst_n = 1;
    tick_clk();
  endtask

  // Counts edges until /INT is seen low; strobes are dropped after the first edge.
  task automatic wait_fall(output int k, input int budget);
    k = 0;
    do begin
      tick_clk();
      k++;
      int_start = 0;
      line_tick = 0;
    end while (int_n && k < budget);
  endtask

  // Measures /INT low time, acking so that the ack is sampled d edges after the fall.
  task automatic measure_low(input int d, output int n);
    n = 0;
    do begin
      int_ack = (d > 0 && n == d - 1);
      tick_clk();
      n++;
    end while (!int_n && n < 400);
    int_ack = 0;
  endtask

  typedef struct {
    logic       fen;
    logic       len;
    int         cmp;
    int         nticks;
    int         ack_dly;   // 0: never ack
    logic       exp_fire;
    int         exp_low;
    logic [7:0] exp_vec;
    logic       exp_missed;
  } rec_t;

  rec_t recs[9];

  // Reference model state
  int         m_line, m_low, m_wait, m_src;
  logic [1:0] m_pend;
  logic [7:0] m_vec;
  logic       m_missed, m_overrun;

  task automatic model_reset();
    m_line = 0; m_low = 0; m_wait = 0; m_src = 0;
    m_pend = 2'b00; m_vec = 8'hFF; m_missed = 0; m_overrun = 0;
  endtask

  // m_low: /INT low cycles still to run; m_wait: gap cycles still to run.
  task automatic model_step();
    logic [1:0] old;
    logic fr, ln;
    int nxt;
    nxt = (m_line + 1) % 512;
    fr  = int_start && frame_int_en;
    ln  = LINE_BUILD && line_tick && line_int_en && (line_cmp != 0) && (nxt == int'(line_cmp));
    if (int_start) m_line = 0;
    else if (line_tick) m_line = nxt;
    if (stat_clr) begin m_missed = 0; m_overrun = 0; end
    old = m_pend;
    if (fr) begin if (old[0]) m_overrun = 1; else m_pend[0] = 1; end
    if (ln) begin if (old[1]) m_overrun = 1; else m_pend[1] = 1; end
    if (m_low > 0) begin
      if (int_ack || m_low == 1) begin
        m_pend[m_src] = 0;
        if (!int_ack) m_missed = 1;
        m_low  = 0;
        m_wait = GAP;
      end else begin
        m_low--;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (old != 2'b00) begin
      m_src = old[0] ? 0 : 1;
      m_vec = old[0] ? 8'hFF : 8'hFD;
      m_low = INT_W;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic stay;

    recs[0] = '{1, 0, 0,   0,   100, 1,          100, 8'hFF, 0};
    recs[1] = '{1, 0, 0,   0,   0,   1,          256, 8'hFF, 1};
    recs[2] = '{0, 1, 100, 100, 10,  LINE_BUILD, 10,  8'hFD, 0};
    recs[3] = '{0, 1, 5,   5,   1,   LINE_BUILD, 1,   8'hFD, 0};
    recs[4] = '{0, 1, 0,   520, 5,   0,          0,   8'hFF, 0};
    recs[5] = '{0, 0, 0,   0,   5,   0,          0,   8'hFF, 0};
    recs[6] = '{1, 0, 0,   0,   256, 1,          256, 8'hFF, 0};
    recs[7] = '{0, 1, 511, 511, 3,   LINE_BUILD, 3,   8'hFD, 0};
    recs[8] = '{0, 0, 10,  10,  5,   0,          0,   8'hFF, 0};

    do_reset();
    chk("reset_state", {int_n, int_vector, pend, missed, overrun}, {1'b1, 8'hFF, 2'b00, 1'b0, 1'b0});

    foreach (recs[r]) begin
      do_reset();
      frame_int_en = recs[r].fen;
      line_int_en  = recs[r].len;
      line_cmp     = 9'(recs[r].cmp);
      int_start    = 1;
      for (int i = 0; i < recs[r].nticks; i++) begin
        tick_clk();
        int_start = 0;
        line_tick = 1;
      end
      if (recs[r].exp_fire) begin
        wait_fall(k, 20);
        chk($sformatf("latency_%0d", r), k, 2);
        measure_low(recs[r].ack_dly, n);
        chk($sformatf("low_len_%0d", r), n, recs[r].exp_low);
        chk($sformatf("vector_%0d", r), int_vector, recs[r].exp_vec);
        chk($sformatf("pend_%0d", r), pend, 2'b00);
        chk($sformatf("missed_%0d", r), missed, recs[r].exp_missed);
        stay = 1;
        for (int i = 0; i < GAP; i++) begin
          tick_clk();
          if (!int_n) stay = 0;
        end
        chk($sformatf("gap_high_%0d", r), stay, 1);
        stat_clr = 1;
        tick_clk();
        stat_clr = 0;
        chk($sformatf("stat_clr_%0d", r), {missed, overrun}, 2'b00);
      end else begin
        wait_fall(k, 50);
        chk($sformatf("no_fire_%0d", r), int_n, 1);
        chk($sformatf("no_fire_pend_%0d", r), pend, 2'b00);
      end
    end

    // Collision: frame and line pending together, frame first.
    do_reset();
    frame_int_en = 1; line_int_en = 1; line_cmp = 9'd1;
    int_start = 1;
    tick_clk();
    int_start = 0;
    line_tick = 1;
    wait_fall(k, 20);
    chk("coll_lat", k, 1);
    chk("coll_pend", pend, LINE_BUILD ? 2'b11 : 2'b01);
    chk("coll_vec1", int_vector, 8'hFF);
    measure_low(5, n);
    chk("coll_low1", n, 5);
    chk("coll_pend_after1", pend, LINE_BUILD ? 2'b10 : 2'b00);
    wait_fall(k, 60);
    if (LINE_BUILD) begin
      chk("coll_gap", k, GAP + 1);
      chk("coll_vec2", int_vector, 8'hFD);
      measure_low(3, n);
      chk("coll_low2", n, 3);
      chk("coll_pend_after2", pend, 2'b00);
    end else begin
      chk("coll_single", int_n, 1);
    end

    // Overrun: second frame event while the first is being asserted.
    do_reset();
    frame_int_en = 1;
    int_start = 1;
    wait_fall(k, 20);
    chk("ovr_lat", k, 2);
    int_start = 1;
    tick_clk();
    int_start = 0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_pend", pend, 2'b01);
    measure_low(5, n);
    chk("ovr_low", n, 5);
    wait_fall(k, 60);
    chk("ovr_single", int_n, 1);
    chk("ovr_sticky", overrun, 1);
    stat_clr = 1;
    tick_clk();
    stat_clr = 0;
    chk("ovr_clr", overrun, 0);

    // Reset in the middle of an assertion.
    do_reset();
    frame_int_en = 1;
    int_start = 1;
    wait_fall(k, 20);
    int_start = 1;
    tick_clk();
    int_start = 0;
    repeat (10) tick_clk();
    chk("pre_reset_low", int_n, 0);
    rst_n = 0;
    #1;
    chk("mid_reset", {int_n, int_vector, pend, missed, overrun}, {1'b1, 8'hFF, 2'b00, 1'b0, 1'b0});
    tick_clk();
    rst_n = 1;

    // Randomised run against the reference model.
    do_reset();
    model_reset();
    frame_int_en = 1; line_int_en = 1; line_cmp = 9'd7;
    for (int c = 0; c < 8000; c++) begin
      int_start = ($urandom_range(0, 199) == 0);
      line_tick = ($urandom_range(0, 3) == 0);
      int_ack   = ($urandom_range(0, 39) == 0);
      stat_clr  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 499) == 0) line_cmp = 9'($urandom_range(0, 40));
      if ($urandom_range(0, 299) == 0) frame_int_en = ~frame_int_en;
      if ($urandom_range(0, 299) == 0) line_int_en = ~line_int_en;
      tick_clk();
      model_step();
      chk($sformatf("random_c%0d", c), {int_n, int_vector, pend, missed, overrun},
          {(m_low == 0), m_vec, m_pend, m_missed, m_overrun});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_int_ctrl.md
Name: video_int_ctrl

Overview:
- Schedules the single Z80 /INT line between two video-timed sources.
  - Frame interrupt: from the `int_start` pulse of the vertical sync generator.
  - Line interrupt: fires at a programmable line, counted from frame INT.
- Arbitrates the two sources by fixed priority and times the /INT pulse width.
- Handles CPU acknowledge and supplies the IM2 vector for the serviced source.
- Sits between the video sync blocks and the Z80 bus glue.

Parameters:
- INT_WIDTH, 256: /INT active length in clk cycles (32 T-states at 3.5 MHz with 28 MHz clk); 9-bit counter.
- GAP_CYCLES, 16: minimum /INT inactive gap between two assertions, in clk cycles.
- VEC_FRAME, 8'hFF: vector driven for a frame interrupt.
- VEC_LINE, 8'hFD: vector driven for a line interrupt.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- int_start  in  1  one-clk pulse, frame interrupt event (line 0)
- line_tick  in  1  one-clk pulse per line, from hint_start
- line_cmp  in  9  line number for the line interrupt
- frame_int_en  in  1  frame source enable
- line_int_en  in  1  line source enable
- int_ack  in  1  one-clk pulse, CPU INT acknowledge (M1 & IORQ decoded)
- stat_clr  in  1  one-clk pulse, clears the missed and overrun flags
- int_n  out  1  Z80 /INT, active low
- int_vector  out  8  vector of the currently/last serviced source
- pend  out  2  {line, frame} pending bits
- missed  out  1  sticky: an assertion timed out without ack
- overrun  out  1  sticky: a source event arrived while that source was already pending

Behaviour:
- Reset values: `int_n`=1, `int_vector`=VEC_FRAME, `pend`=0, `missed`=0, `overrun`=0. FSM in IDLE, line counter 0.
- Line counter (9 bits):
  - `int_start` loads 0.
  - Otherwise `line_tick` increments it, wrapping 511 to 0.
  - If both arrive in the same cycle, `int_start` wins.
- Line event: `line_tick` & `line_int_en` & (counter+1 == `line_cmp`), i.e. the next line value matches. `line_cmp`=0 never fires, because line 0 is the frame event.
- Frame event: `int_start` & `frame_int_en`.
- Each event sets its pend bit on the next clk edge.
  - If that bit is already set, or its source is in service, set `overrun`; the event is not queued twice.
- Clearing an enable does not clear an already-set pend bit.
- FSM:
  - IDLE: if any pend bit is set, go to ASSERT next cycle.
    - Select frame if pend[0], else line; frame has priority.
    - Latch `int_vector`, drive `int_n`=0, load the width counter with INT_WIDTH-1.
  - ASSERT:
    - `int_n`=0; the counter decrements each clk.
    - On `int_ack`: clear the serviced pend bit, `int_n`=1 next cycle, go to GAP.
    - Counter reaching 0 without ack: same as ack, and set `missed`.
    - Ack and expiry in the same cycle count as ack; `missed` is not set.
  - GAP: `int_n`=1 for GAP_CYCLES cycles, then IDLE.
- `int_ack` outside ASSERT is ignored.
- Latency: event pulse to `int_n` low is 2 clk from IDLE (pend set, then FSM).
- `int_vector` holds its value until the next ASSERT entry.
- `stat_clr` clears `missed` and `overrun`. If a flag set and `stat_clr` coincide, set wins.
- `rst_n` low at any time, including mid-ASSERT: immediately return to the reset values, with `int_n`=1 asynchronously.

Optional Feature:
- Macro: VIDEO_INT_LINE_EN.
- Defined: the line source, line counter and `line_cmp` compare are present as above.
- Undefined:
  - Line counter and compare are removed; pend[1] is tied 0.
  - `line_tick`, `line_cmp` and `line_int_en` are ignored.
  - `int_vector` is always VEC_FRAME.
  - Frame behaviour and timing are otherwise identical.

Decomposition:
- Shared video package/include:
  - FSM state encodings (IDLE, ASSERT, GAP).
  - Source index constants (SRC_FRAME=0, SRC_LINE=1).
  - Default VEC_FRAME/VEC_LINE values.
  - 9-bit line-number width, shared with the sync generators.
- One natural sub-module: video_int_linecnt (line counter plus compare, producing the line event). It is instantiated only under VIDEO_INT_LINE_EN.

Test Plan:
1. Frame only: `frame_int_en`=1, pulse `int_start`, ack 100 clk after `int_n` falls → `int_n` low exactly 100 clk, `int_vector`=FF, pend=00, `missed`=0.
2. No ack: `int_start` with ack never given → `int_n` low exactly 256 clk, then high for at least 16 clk; `missed`=1; `stat_clr` → `missed`=0.
3. Line interrupt: `line_cmp`=100, `int_start` then 100 `line_tick` pulses → `int_n` falls 2 clk after the 100th tick; ack → `int_vector`=FD.
4. Collision: line and frame events pending together (`line_cmp`=1, tick in the cycle after `int_start`) → frame serviced first (FF); after GAP, line serviced (FD); two separate `int_n` pulses.
5. Overrun: second `int_start` while frame is in ASSERT → `overrun`=1, only one frame assertion occurs.
6. Reset mid-ASSERT: `rst_n` low → `int_n`=1 within the same cycle, all outputs at reset values; build without VIDEO_INT_LINE_EN → `line_tick` activity never asserts `int_n`.
